uart_tx_fifo: RTL and testbench

Transmit buffer that sits directly upstream of the UART transmitter. It accepts bytes from the CPU/bus side into a synchronous FIFO and issues them one at a time over the transmitter's write/write_ready handshake. The transmitter samples its data bits over the whole frame, so this block holds each byte stable in a holding register until the frame completes. Decouples CPU store bursts from the serial bit rate.

---
 rtl/uart_tx_fifo.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of the UART transmitter.
// Bytes from the bus are queued in a circular buffer. A small FSM pops one
// byte at a time into a holding register and hands it over with a one-cycle
// write pulse. The holding register stays stable for the whole frame.
module uart_tx_fifo #(
  parameter int DataBitsSize = 8,
  parameter int Depth        = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DataBitsSize-1:0]      in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  input  logic                         clr_overflow,
  output logic                         overflow,
  output logic [$clog2(Depth+1)-1:0]   count,
  output logic                         empty,
  output logic                         tx_write,
  output logic [DataBitsSize-1:0]      tx_data,
  input  logic                         tx_ready,
  output logic                         tx_busy
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);

  typedef enum logic [1:0] {
    Idle     = 2'd0,
    WaitAck  = 2'd1,
    WaitDone = 2'd2
  } state_e;

  logic [DataBitsSize-1:0] mem_q [Depth];

  logic [PtrW-1:0]         wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]         rdPtr_q, rdPtr_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    overflow_q, overflow_d;
  state_e                  state_q, state_d;
  logic                    txWrite_q, txWrite_d;
  logic [DataBitsSize-1:0] txData_q, txData_d;

  logic full;
  logic push;
  logic launch;

  // full is taken from the registered count, so a pop in the same cycle
  // never makes room for a push.
  assign full     = (count_q == CntW'(Depth));
  assign in_ready = !full;
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_write = txWrite_q;
  assign tx_data  = txData_q;
  assign tx_busy  = (state_q != Idle);

  // A push accepted during a flush would be thrown away anyway, so it is
  // suppressed entirely, including its memory write.
  assign push = in_valid && in_ready && !flush;

  // FIFO pointer, count and overflow next-state; flush overrides everything.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + PtrW'(1);
      end
      if (launch) begin
        rdPtr_d = rdPtr_q + PtrW'(1);
      end
      if (push && !launch) begin
        count_d = count_q + CntW'(1);
      end else if (!push && launch) begin
        count_d = count_q - CntW'(1);
      end
    end
    if (in_valid && !in_ready && !flush) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // FIFO control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= in_data;
    end
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= Idle;
      txWrite_q <= 1'b0;
      txData_q  <= '0;
    end else begin
      state_q   <= state_d;
      txWrite_q <= txWrite_d;
      txData_q  <= txData_d;
    end
  end

  // FSM next state: launch, wait for the transmitter to go busy, then idle again.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Idle: begin
        if (launch) begin
          state_d = WaitAck;
        end
      end
      WaitAck: begin
        if (!tx_ready) begin
          state_d = WaitDone;
        end
      end
      WaitDone: begin
        if (tx_ready) begin
          state_d = Idle;
        end
      end
      default: begin
        state_d = Idle;
      end
    endcase
  end

  // FSM outputs: a launch pops the head into the holding register and pulses write.
  always_comb begin
    launch    = 1'b0;
    txWrite_d = 1'b0;
    txData_d  = txData_q;
    if (state_q == Idle && !empty && tx_ready) begin
      launch    = 1'b1;
      txWrite_d = 1'b1;
      txData_d  = mem_q[rdPtr_q];
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo (DataBitsSize=8, Depth=16).
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic       clr_overflow;
  logic       overflow;
  logic [4:0] count;
  logic       empty;
  logic       tx_write;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_busy;

  int checks   = 0;
  int failures = 0;

  // Transmitter model: after each write pulse, ready drops for holdLen cycles.
  int holdLen = 50;
  int txHold  = 0;

  uart_tx_fifo #(
    .DataBitsSize(8),
    .Depth(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flush(flush),
    .clr_overflow(clr_overflow),
    .overflow(overflow),
    .count(count),
    .empty(empty),
    .tx_write(tx_write),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .tx_busy(tx_busy)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the transmitter model driving tx_ready.
  task automatic txStep(output logic wrote, output logic [7:0] data);
    tick();
    wrote = tx_write;
    data  = tx_data;
    if (tx_write) begin
      txHold   = holdLen;
      tx_ready = 1'b0;
    end else if (txHold > 0) begin
      txHold--;
      if (txHold == 0) tx_ready = 1'b1;
    end
  endtask

  // Push one byte (one cycle of in_valid).
  task automatic pushByte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0;
    clr_overflow = 1'b0; tx_ready = 1'b1;
    tick();
    tick();
    checks++; if (count !== 5'd0)   begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)   begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (tx_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_write got=%b exp=0", tx_write); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_busy got=%b exp=0", tx_busy); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int bad;
    tx_ready = 1'b1;
    pushByte(8'hA5);
    checks++; if (count !== 5'd1)   begin failures++; $display("[TB] FAIL single_count_after_push got=%0d exp=1", count); end
    checks++; if (tx_write !== 1'b0) begin failures++; $display("[TB] FAIL single_write_early got=%b exp=0", tx_write); end
    tick();
    checks++; if (tx_write !== 1'b1) begin failures++; $display("[TB] FAIL single_write_pulse got=%b exp=1", tx_write); end
    checks++; if (tx_data !== 8'hA5) begin failures++; $display("[TB] FAIL single_tx_data got=%h exp=a5", tx_data); end
    checks++; if (count !== 5'd0)   begin failures++; $display("[TB] FAIL single_count_after_pop got=%0d exp=0", count); end
    checks++; if (tx_busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy got=%b exp=1", tx_busy); end
    tx_ready = 1'b0;
    tick();
    checks++; if (tx_write !== 1'b0) begin failures++; $display("[TB] FAIL single_write_width got=%b exp=0", tx_write); end
    bad = 0;
    repeat (100) begin
      tick();
      if (tx_data !== 8'hA5 || tx_write !== 1'b0 || tx_busy !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL single_hold_stable got=%0d exp=0 bad cycles", bad); end
    tx_ready = 1'b1;
    tick();
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("[TB] FAIL single_back_idle got=%b exp=0", tx_busy); end
    checks++; if (empty !== 1'b1)   begin failures++; $display("[TB] FAIL single_empty got=%b exp=1", empty); end
    checks++; if (tx_data !== 8'hA5) begin failures++; $display("[TB] FAIL single_data_after got=%h exp=a5", tx_data); end
    tick();
    checks++; if (tx_write !== 1'b0) begin failures++; $display("[TB] FAIL single_no_relaunch got=%b exp=0", tx_write); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expData [3];
    logic       w;
    logic       prevW;
    logic [7:0] d;
    logic [7:0] lock;
    int n, badStable, badPulse;
    expData[0] = 8'h11; expData[1] = 8'h22; expData[2] = 8'h33;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) pushByte(expData[i]);
    checks++; if (count !== 5'd3) begin failures++; $display("[TB] FAIL b2b_count_full got=%0d exp=3", count); end
    holdLen = 50; txHold = 0; tx_ready = 1'b1;
    n = 0; badStable = 0; badPulse = 0; prevW = 1'b0; lock = 8'h00;
    for (int c = 0; c < 400 && !(n == 3 && tx_busy == 1'b0); c++) begin
      txStep(w, d);
      if (w) begin
        if (n < 3) begin
          checks++; if (d !== expData[n]) begin failures++; $display("[TB] FAIL b2b_data%0d got=%h exp=%h", n, d, expData[n]); end
          checks++; if (count !== 5'(2 - n)) begin failures++; $display("[TB] FAIL b2b_count%0d got=%0d exp=%0d", n, count, 2 - n); end
        end
        lock = d;
        n++;
      end else if (tx_busy && tx_data !== lock) begin
        badStable++;
      end
      if (w && prevW) badPulse++;
      prevW = w;
    end
    checks++; if (n !== 3)         begin failures++; $display("[TB] FAIL b2b_pulses got=%0d exp=3", n); end
    checks++; if (badStable !== 0) begin failures++; $display("[TB] FAIL b2b_stable got=%0d exp=0 bad cycles", badStable); end
    checks++; if (badPulse !== 0)  begin failures++; $display("[TB] FAIL b2b_pulse_width got=%0d exp=0", badPulse); end
    checks++; if (count !== 5'd0)  begin failures++; $display("[TB] FAIL b2b_count_end got=%0d exp=0", count); end
  endtask

  task automatic test_overflow();
    logic       w;
    logic [7:0] d;
    int n, extra;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) pushByte(8'(8'h40 + i));
    checks++; if (count !== 5'd16)   begin failures++; $display("[TB] FAIL ovf_count16 got=%0d exp=16", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL ovf_in_ready got=%b exp=0", in_ready); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_early got=%b exp=0", overflow); end
    clr_overflow = 1'b1;
    pushByte(8'hEE);
    clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set_wins got=%b exp=1", overflow); end
    checks++; if (count !== 5'd16)   begin failures++; $display("[TB] FAIL ovf_count_after got=%0d exp=16", count); end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear got=%b exp=0", overflow); end
    holdLen = 3; txHold = 0; tx_ready = 1'b1; n = 0;
    for (int c = 0; c < 300 && !(n == 16 && tx_busy == 1'b0); c++) begin
      txStep(w, d);
      if (w) begin
        checks++; if (d !== 8'(8'h40 + n)) begin failures++; $display("[TB] FAIL ovf_drain%0d got=%h exp=%h", n, d, 8'(8'h40 + n)); end
        n++;
      end
    end
    checks++; if (n !== 16) begin failures++; $display("[TB] FAIL ovf_drain_count got=%0d exp=16", n); end
    extra = 0;
    repeat (4) begin
      tick();
      if (tx_write) extra++;
    end
    checks++; if (extra !== 0)    begin failures++; $display("[TB] FAIL ovf_dropped_emitted got=%0d exp=0", extra); end
    checks++; if (count !== 5'd0) begin failures++; $display("[TB] FAIL ovf_count_drained got=%0d exp=0", count); end
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) pushByte(8'(8'h60 + i));
    checks++; if (count !== 5'd4) begin failures++; $display("[TB] FAIL wrap_count got=%0d exp=4", count); end
    txHold = 0; tx_ready = 1'b1; n = 0;
    for (int c = 0; c < 100 && !(n == 4 && tx_busy == 1'b0); c++) begin
      txStep(w, d);
      if (w) begin
        checks++; if (d !== 8'(8'h60 + n)) begin failures++; $display("[TB] FAIL wrap_data%0d got=%h exp=%h", n, d, 8'(8'h60 + n)); end
        n++;
      end
    end
    checks++; if (n !== 4) begin failures++; $display("[TB] FAIL wrap_pulses got=%0d exp=4", n); end
  endtask

  task automatic test_full_pop();
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) pushByte(8'(8'h70 + i));
    tx_ready = 1'b1;
    pushByte(8'h5A);
    checks++; if (tx_write !== 1'b1) begin failures++; $display("[TB] FAIL fullpop_launch got=%b exp=1", tx_write); end
    checks++; if (tx_data !== 8'h70) begin failures++; $display("[TB] FAIL fullpop_data got=%h exp=70", tx_data); end
    checks++; if (count !== 5'd15)   begin failures++; $display("[TB] FAIL fullpop_count got=%0d exp=15", count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL fullpop_overflow got=%b exp=1", overflow); end
    tx_ready = 1'b0;
    tick();
    flush = 1'b1; clr_overflow = 1'b1;
    tick();
    flush = 1'b0; clr_overflow = 1'b0; tx_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    int extra;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) pushByte(8'(8'h81 + i));
    checks++; if (count !== 5'd5) begin failures++; $display("[TB] FAIL flush_count5 got=%0d exp=5", count); end
    tx_ready = 1'b1;
    tick();
    checks++; if (tx_data !== 8'h81) begin failures++; $display("[TB] FAIL flush_first_data got=%h exp=81", tx_data); end
    tx_ready = 1'b0;
    tick();
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 5'd0)   begin failures++; $display("[TB] FAIL flush_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)   begin failures++; $display("[TB] FAIL flush_empty got=%b exp=1", empty); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL flush_no_overflow got=%b exp=0", overflow); end
    checks++; if (tx_data !== 8'h81) begin failures++; $display("[TB] FAIL flush_tx_data got=%h exp=81", tx_data); end
    checks++; if (tx_busy !== 1'b1) begin failures++; $display("[TB] FAIL flush_busy got=%b exp=1", tx_busy); end
    tx_ready = 1'b1;
    extra = 0;
    repeat (10) begin
      tick();
      if (tx_write) extra++;
    end
    checks++; if (extra !== 0)      begin failures++; $display("[TB] FAIL flush_no_more_writes got=%0d exp=0", extra); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle got=%b exp=0", tx_busy); end
  endtask

  task automatic test_mid_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) pushByte(8'(8'hC0 + i));
    tx_ready = 1'b1;
    tick();
    checks++; if (tx_write !== 1'b1) begin failures++; $display("[TB] FAIL mrst_pre_write got=%b exp=1", tx_write); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (tx_write !== 1'b0) begin failures++; $display("[TB] FAIL mrst_tx_write got=%b exp=0", tx_write); end
    checks++; if (tx_busy !== 1'b0)  begin failures++; $display("[TB] FAIL mrst_tx_busy got=%b exp=0", tx_busy); end
    checks++; if (count !== 5'd0)    begin failures++; $display("[TB] FAIL mrst_count got=%0d exp=0", count); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("[TB] FAIL mrst_tx_data got=%h exp=00", tx_data); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL mrst_overflow got=%b exp=0", overflow); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL mrst_in_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (tx_write !== 1'b0) begin failures++; $display("[TB] FAIL mrst_data_lost got=%b exp=0", tx_write); end
  endtask

  // Scenario sequence.
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0;
    clr_overflow = 1'b0; tx_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_flush();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
